fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core.
- Owns the PC and drives the instruction-memory request port.
- Delivers instruction_D / pc_plus_four_D / valid_D to the decode stage.
- Consumes the decode stage's jump_address / pc_src redirect and the hazard unit's stalls.

Parameters:
- RESET_PC, 32'h0040_0000: PC loaded on reset (MARS text base).
- ADDR_W, 32: PC and imem address width; must be 32 in this core.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_F  in  1  hazard unit: hold PC.
- stall_D  in  1  hazard unit: hold IF/ID register.
- pc_src  in  1  decode: take jump_address.
- jump_address  in  32  decode: redirect target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word address, equal to the current PC.
- imem_ready  in  1  memory: imem_rdata valid this cycle; may be high in the request cycle.
- imem_rdata  in  32  fetched instruction word.
- instruction_D  out  32  IF/ID: instruction to decode.
- pc_plus_four_D  out  32  IF/ID: PC+4 of that instruction.
- valid_D  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_busy  out  1  to hazard unit: imem access outstanding, no word delivered this cycle.

Behaviour:
- Reset (synchronous, active-high):
  - pc_F=RESET_PC; state=FETCH; imem_req=0 while reset is high.
  - instruction_D=32'h0 (sll $0 NOP); pc_plus_four_D=RESET_PC; valid_D=0.
  - hold_buf invalid; redirect_pending=0.
  - Reset mid-access abandons the access; the word is ignored when it returns.
- redirect = pc_src & valid_D & ~stall_D. pc_src is ignored on bubbles and stalled decode.
- Handshake:
  - imem_req=1 in FETCH and DRAIN.
  - imem_addr=pc_F, held stable from req assertion until imem_ready.
  - Completion = imem_req & imem_ready. Zero-wait memory gives one instruction per cycle.
- FETCH:
  - Completion, no redirect, ~stall_D: IF/ID <= {imem_rdata, pc_F+4, 1}; pc_F <= pc_F+4.
  - Completion, ~redirect, stall_D (or stall_F): word -> hold_buf; go to HOLD; pc_F and IF/ID unchanged.
  - Completion with redirect: word discarded; IF/ID <= bubble; pc_F <= jump_address.
  - No completion, redirect: target -> redirect_pending; IF/ID <= bubble; go to DRAIN.
  - No completion, ~stall_D: IF/ID <= bubble (valid_D=0, instruction 0, pc_plus_four_D unchanged).
- DRAIN:
  - Keep requesting the old address. IF/ID <= bubble unless stall_D.
  - On completion: discard the word; pc_F <= pending target; redirect_pending=0; go to FETCH.
- HOLD:
  - imem_req=0.
  - When ~stall_D & ~stall_F: IF/ID <= hold_buf; pc_F <= pc_F+4; go to FETCH.
  - Redirect in HOLD: drop hold_buf; IF/ID <= bubble; pc_F <= jump_address; go to FETCH.
- Priority per cycle: reset > redirect > stall > normal advance.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. pc_F[1:0] always 0; jump_address[1:0] is forced to 0.
- fetch_busy = imem_req & ~imem_ready.

Optional Feature:
- Macro FETCH_DELAY_SLOT_EN.
- Defined (MIPS delay slot): a redirect does not squash the word being fetched in F.
  - That word is delivered as a valid instruction.
  - The target is latched in redirect_pending; pc_F <= target once the slot word has been delivered (including via HOLD).
  - DRAIN is never entered.
- Undefined: squash behaviour as above; the wrong-path word is discarded and a bubble is inserted.

Decomposition:
- Shared package mips_pkg: RESET_PC default, NOP_INSTR=32'h0000_0000, fetch FSM state encoding (FETCH, DRAIN, HOLD), word-width constant.
- One sub-module: if_id_register.
  - Loads {instruction, pc_plus_four, valid} with enable (~stall_D) and flush (bubble) inputs.
  - Reset value: NOP / RESET_PC / 0.

Test Plan:
- Reset, then zero-wait memory returning 32'h2008_0005 at 0x0040_0000 -> next edge: instruction_D=32'h2008_0005, pc_plus_four_D=0x0040_0004, valid_D=1; PC steps by 4 every cycle.
- imem_ready low for 3 cycles at 0x0040_0008 -> imem_addr stable all 3 cycles; valid_D=0 and fetch_busy=1 for 3 cycles; word delivered on cycle 4.
- stall_D high for 2 cycles while a word returns -> IF/ID unchanged, imem_req=0 in HOLD; buffered word appears the cycle after stall drops, with no duplicate or skipped PC.
- pc_src=1, jump_address=0x0040_0100, valid_D=1:
  - Undefined macro: next instruction_D is a bubble, then the word from 0x0040_0100.
  - FETCH_DELAY_SLOT_EN: the PC+4 word is delivered, then 0x0040_0100.
- Redirect to 0x0040_0200 while memory is stalled 2 cycles -> DRAIN; the returned old word is never in IF/ID; imem_addr switches to 0x0040_0200 after completion.
- Reset asserted mid-DRAIN -> next cycle: pc_F=RESET_PC, valid_D=0, redirect_pending cleared; late imem_ready ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch FSM encoding for the MIPS core
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] pc_plus_four(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with load enable and bubble flush
// A flushed load writes a NOP with valid cleared and keeps the previous pc_plus_four.
module if_id_register
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [WORD_W-1:0] instruction_in,
  input  logic [WORD_W-1:0] pc_plus_four_in,
  output logic [WORD_W-1:0] instruction_out,
  output logic [WORD_W-1:0] pc_plus_four_out,
  output logic              valid_out
);
  logic [WORD_W-1:0] instruction_q, instruction_d;
  logic [WORD_W-1:0] pc_plus_four_q, pc_plus_four_d;
  logic              valid_q, valid_d;

  always_comb begin
    instruction_d  = instruction_q;
    pc_plus_four_d = pc_plus_four_q;
    valid_d        = valid_q;
    if (enable) begin
      if (flush) begin
        instruction_d = NOP_INSTR;
        valid_d       = 1'b0;
      end else begin
        instruction_d  = instruction_in;
        pc_plus_four_d = pc_plus_four_in;
        valid_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_q  <= NOP_INSTR;
      pc_plus_four_q <= RESET_PC;
      valid_q        <= 1'b0;
    end else begin
      instruction_q  <= instruction_d;
      pc_plus_four_q <= pc_plus_four_d;
      valid_q        <= valid_d;
    end
  end

  assign instruction_out  = instruction_q;
  assign pc_plus_four_out = pc_plus_four_q;
  assign valid_out        = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage: PC, imem handshake, IF/ID register
// FETCH_DELAY_SLOT_EN: redirects keep the in-flight word as the delay slot instead of squashing it.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] jump_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instruction_D,
  output logic [WORD_W-1:0] pc_plus_four_D,
  output logic              valid_D,
  output logic              fetch_busy
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] hold_buf_q, hold_buf_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pending_addr_q, pending_addr_d;
  logic              redirect, complete, deliver;
  logic [WORD_W-1:0] deliver_instr;
  logic [ADDR_W-1:0] target;

  assign imem_req   = ~reset & (state_q != HOLD);
  assign imem_addr  = pc_q;
  assign complete   = imem_req & imem_ready;
  assign fetch_busy = imem_req & ~imem_ready;
  assign redirect   = pc_src & valid_D & ~stall_D;
  assign target     = jump_address & ~32'h3;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_buf_d     = hold_buf_q;
    pending_d      = pending_q;
    pending_addr_d = pending_addr_q;
    deliver        = 1'b0;
    deliver_instr  = imem_rdata;
`ifdef FETCH_DELAY_SLOT_EN
    if (redirect) begin
      pending_d      = 1'b1;
      pending_addr_d = target;
    end
    case (state_q)
      HOLD: begin
        if (~stall_D & ~stall_F) begin
          deliver       = 1'b1;
          deliver_instr = hold_buf_q;
          state_d       = FETCH;
        end
      end
      default: begin
        if (complete) begin
          if (stall_D | stall_F) begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end else begin
            deliver = 1'b1;
          end
        end
      end
    endcase
    // The slot word is out, so the pending target (if any) now becomes the PC.
    if (deliver) begin
      pc_d      = pending_d ? pending_addr_d : pc_plus_four(pc_q);
      pending_d = 1'b0;
    end
`else
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (complete) begin
            pc_d = target;
          end else begin
            pending_d      = 1'b1;
            pending_addr_d = target;
            state_d        = DRAIN;
          end
        end else if (complete) begin
          if (stall_D | stall_F) begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end else begin
            deliver = 1'b1;
            pc_d    = pc_plus_four(pc_q);
          end
        end
      end
      DRAIN: begin
        if (complete) begin
          pc_d      = pending_addr_q;
          pending_d = 1'b0;
          state_d   = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (~stall_D & ~stall_F) begin
          deliver       = 1'b1;
          deliver_instr = hold_buf_q;
          pc_d          = pc_plus_four(pc_q);
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      hold_buf_q     <= NOP_INSTR;
      pending_q      <= 1'b0;
      pending_addr_q <= RESET_PC;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_buf_q     <= hold_buf_d;
      pending_q      <= pending_d;
      pending_addr_q <= pending_addr_d;
    end
  end

  // Whenever decode advances without a delivered word it receives a bubble.
  if_id_register #(.RESET_PC(RESET_PC)) u_if_id (
    .clock           (clock),
    .reset           (reset),
    .enable          (~stall_D),
    .flush           (~deliver),
    .instruction_in  (deliver_instr),
    .pc_plus_four_in (pc_plus_four(pc_q)),
    .instruction_out (instruction_D),
    .pc_plus_four_out(pc_plus_four_D),
    .valid_out       (valid_D)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table plus randomized scoreboard for fetch_stage
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_F = 1'b0, stall_D = 1'b0, pc_src = 1'b0, imem_ready = 1'b0;
  logic [31:0] jump_address = 32'h0;
  logic [31:0] imem_rdata, imem_addr, instruction_D, pc_plus_four_D;
  logic        imem_req, valid_D, fetch_busy;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h2008_0005 : (a ^ 32'hA5A5_0000);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall_F       (stall_F),
    .stall_D       (stall_D),
    .pc_src        (pc_src),
    .jump_address  (jump_address),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction_D (instruction_D),
    .pc_plus_four_D(pc_plus_four_D),
    .valid_D       (valid_D),
    .fetch_busy    (fetch_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ctl = {reset, stall_D, stall_F, pc_src}; flg = {imem_req, fetch_busy, valid_D}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] ja;
    logic        rdy;
    logic [2:0]  flg;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[20];

  logic [31:0] exp_pc, tgt, old_instr, old_pc4, prev_addr;
  logic        tgt_v, old_valid, prev_wait, redir, sd;
  int          delivered;

  initial begin
    vecs[0]  = '{4'b0000, 32'h0,         1'b1, 3'b100, 32'h0040_0000, 32'h0,         32'h0040_0000};
    vecs[1]  = '{4'b0000, 32'h0,         1'b1, 3'b101, 32'h0040_0004, 32'h2008_0005, 32'h0040_0004};
    vecs[2]  = '{4'b0000, 32'h0,         1'b0, 3'b111, 32'h0040_0008, 32'hA5E5_0004, 32'h0040_0008};
    vecs[3]  = '{4'b0000, 32'h0,         1'b0, 3'b110, 32'h0040_0008, 32'h0,         32'h0040_0008};
    vecs[4]  = '{4'b0000, 32'h0,         1'b0, 3'b110, 32'h0040_0008, 32'h0,         32'h0040_0008};
    vecs[5]  = '{4'b0000, 32'h0,         1'b1, 3'b100, 32'h0040_0008, 32'h0,         32'h0040_0008};
    vecs[6]  = '{4'b0100, 32'h0,         1'b1, 3'b101, 32'h0040_000C, 32'hA5E5_0008, 32'h0040_000C};
    vecs[7]  = '{4'b0100, 32'h0,         1'b1, 3'b001, 32'h0040_000C, 32'hA5E5_0008, 32'h0040_000C};
    vecs[8]  = '{4'b0000, 32'h0,         1'b1, 3'b001, 32'h0040_000C, 32'hA5E5_0008, 32'h0040_000C};
    vecs[9]  = '{4'b0000, 32'h0,         1'b1, 3'b101, 32'h0040_0010, 32'hA5E5_000C, 32'h0040_0010};
    vecs[10] = '{4'b0001, 32'h0040_0101, 1'b1, 3'b101, 32'h0040_0014, 32'hA5E5_0010, 32'h0040_0014};
`ifdef FETCH_DELAY_SLOT_EN
    vecs[11] = '{4'b0000, 32'h0,         1'b1, 3'b101, 32'h0040_0100, 32'hA5E5_0014, 32'h0040_0018};
`else
    vecs[11] = '{4'b0000, 32'h0,         1'b1, 3'b100, 32'h0040_0100, 32'h0,         32'h0040_0014};
`endif
    vecs[12] = '{4'b0001, 32'h0040_0200, 1'b0, 3'b111, 32'h0040_0104, 32'hA5E5_0100, 32'h0040_0104};
    vecs[13] = '{4'b0001, 32'h0040_0200, 1'b0, 3'b110, 32'h0040_0104, 32'h0,         32'h0040_0104};
    vecs[14] = '{4'b0000, 32'h0,         1'b1, 3'b100, 32'h0040_0104, 32'h0,         32'h0040_0104};
`ifdef FETCH_DELAY_SLOT_EN
    vecs[15] = '{4'b0000, 32'h0,         1'b1, 3'b101, 32'h0040_0200, 32'hA5E5_0104, 32'h0040_0108};
`else
    vecs[15] = '{4'b0000, 32'h0,         1'b1, 3'b100, 32'h0040_0200, 32'h0,         32'h0040_0104};
`endif
    vecs[16] = '{4'b0001, 32'h0040_0300, 1'b0, 3'b111, 32'h0040_0204, 32'hA5E5_0200, 32'h0040_0204};
    vecs[17] = '{4'b1000, 32'h0,         1'b0, 3'b000, 32'h0040_0204, 32'h0,         32'h0040_0204};
    vecs[18] = '{4'b0000, 32'h0,         1'b1, 3'b100, 32'h0040_0000, 32'h0,         32'h0040_0000};
    vecs[19] = '{4'b0000, 32'h0,         1'b1, 3'b101, 32'h0040_0004, 32'h2008_0005, 32'h0040_0004};

    // Reset state while reset is still asserted.
    @(negedge clock);
    @(negedge clock);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0040_0000);
    check("rst_valid", {31'h0, valid_D}, 32'h0);
    check("rst_instr", instruction_D, 32'h0);
    check("rst_pc4", pc_plus_four_D, 32'h0040_0000);

    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clock);
      {reset, stall_D, stall_F, pc_src} = vecs[i].ctl;
      jump_address = vecs[i].ja;
      imem_ready   = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_flags", i), {29'h0, imem_req, fetch_busy, valid_D}, {29'h0, vecs[i].flg});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d_instr", i), instruction_D, vecs[i].instr);
      check($sformatf("v%0d_pc4", i), pc_plus_four_D, vecs[i].pc4);
    end

    // Randomized run: the delivered instruction stream must follow the program path.
    @(negedge clock);
    reset = 1'b1; stall_D = 1'b0; stall_F = 1'b0; pc_src = 1'b0; imem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_pc = 32'h0040_0000; tgt = 32'h0; tgt_v = 1'b0;
    prev_wait = 1'b0; prev_addr = 32'h0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clock);
      stall_D    = ($urandom_range(0, 99) < 20);
      stall_F    = ($urandom_range(0, 99) < 10);
      pc_src     = ($urandom_range(0, 99) < 15);
      imem_ready = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 9) == 0) jump_address = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else jump_address = 32'h0040_0000 | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      #1;
      if (imem_req) check("rnd_busy", {31'h0, fetch_busy}, {31'h0, ~imem_ready});
      if (prev_wait && imem_req) check("rnd_addr_stable", imem_addr, prev_addr);
      prev_wait = imem_req & ~imem_ready;
      prev_addr = imem_addr;
      redir     = pc_src & valid_D & ~stall_D;
      sd        = stall_D;
      old_instr = instruction_D; old_pc4 = pc_plus_four_D; old_valid = valid_D;
      @(posedge clock);
      #1;
      if (sd) begin
        check("rnd_hold_instr", instruction_D, old_instr);
        check("rnd_hold_pc4", pc_plus_four_D, old_pc4);
        check("rnd_hold_valid", {31'h0, valid_D}, {31'h0, old_valid});
      end else begin
        if (redir) begin
`ifdef FETCH_DELAY_SLOT_EN
          tgt_v = 1'b1;
          tgt   = jump_address & ~32'h3;
`else
          exp_pc = jump_address & ~32'h3;
          check("rnd_squash", {31'h0, valid_D}, 32'h0);
`endif
        end
        if (valid_D) begin
          check("rnd_instr", instruction_D, mem_word(exp_pc));
          check("rnd_pc4", pc_plus_four_D, exp_pc + 32'd4);
          exp_pc = tgt_v ? tgt : exp_pc + 32'd4;
          tgt_v  = 1'b0;
          delivered++;
        end else begin
          check("rnd_bubble", instruction_D, 32'h0);
        end
      end
    end
    check("rnd_progress", {31'h0, delivered > 300}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
